// File: rtl/signal_field_serializer.sv
// Builds the 802.11a SIGNAL word (RATE, reserved, LENGTH, parity, tail) and
// shifts it out LSB first, one bit per valid/ready handshake.
module signal_field_serializer #(
  parameter int RATE_W = 4,
  parameter int LEN_W  = 12,
  parameter int TAIL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RATE_W-1:0] rate,
  input  logic [LEN_W-1:0]  length,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N     = RATE_W + 1 + LEN_W + 1 + TAIL_W;
  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             legal;
  logic             parity;
  logic             transfer;
  logic [N-1:0]     assembled;

  // Only a MSB-set RATE code is a real 802.11a rate; an empty PSDU is rejected too.
  assign legal     = rate[RATE_W-1] && (length != '0);
  assign parity    = ^{rate, length};
  assign assembled = {{TAIL_W{1'b0}}, parity, length, 1'b0, rate};
  assign transfer  = valid_q && bit_ready;

  // The word shifts right on each transfer, so its LSB is always the bit on the wire.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            word_d  = assembled;
            idx_d   = '0;
            state_d = SEND;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (transfer) begin
          word_d = {1'b0, word_q[N-1:1]};
          if (idx_q == IDX_W'(N - 1)) begin
            idx_d   = '0;
            state_d = FIN;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bit_out   = word_q[0];
  assign bit_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_signal_field_serializer.sv
// Scoreboard bench for signal_field_serializer: expected bits are queued at
// start and popped on each observed valid/ready transfer.
module tb_signal_field_serializer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] length;
  logic        bit_ready;
  logic        bit_out;
  logic        bit_valid;
  logic        busy;
  logic        done;
  logic        err;

  int   vectors = 0;
  int   miscompares = 0;
  logic expQ[$];

  signal_field_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rate      (rate),
    .length    (length),
    .bit_ready (bit_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] modelWord(input logic [3:0] r, input logic [11:0] l);
    logic [23:0] w;
    int ones;
    w = '0;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = r[i];
      if (r[i]) ones++;
    end
    for (int i = 0; i < 12; i++) begin
      w[5 + i] = l[i];
      if (l[i]) ones++;
    end
    w[17] = (ones % 2 == 1);
    return w;
  endfunction

  task automatic pushWord(input logic [23:0] w);
    for (int i = 0; i < 24; i++) expQ.push_back(w[i]);
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid && bit_ready) begin
        if (expQ.size() == 0) checkOutput("extraBit", 32'(bit_out), 32'hEEEE);
        else checkOutput("serialBit", 32'(bit_out), 32'(expQ.pop_front()));
      end
      if (err) checkOutput("errWithBusy", 32'(busy), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [11:0] l);
    @(posedge clk);
    #1;
    rate   = r;
    length = l;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int expCycles);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checkOutput("latencyValid", 32'(bit_valid), 32'd1);
        checkOutput("latencyBusy", 32'(busy), 32'd1);
      end
      if (done) break;
      if (n > 80) break;
    end
    checkOutput("doneCycle", 32'(n), 32'(expCycles));
    checkOutput("finValid", 32'(bit_valid), 32'd0);
    checkOutput("finBusy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("donePulse", 32'(done), 32'd0);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic stallAt(input int idx, input int len, input logic expBit);
    repeat (idx) @(posedge clk);
    #1;
    bit_ready = 1'b0;
    repeat (len) begin
      @(negedge clk);
      checkOutput("stallValid", 32'(bit_valid), 32'd1);
      checkOutput("stallBit", 32'(bit_out), 32'(expBit));
    end
    @(posedge clk);
    #1;
    bit_ready = 1'b1;
  endtask

  task automatic runField(input logic [3:0] r, input logic [11:0] l, input logic [23:0] w,
                          input int sIdx, input int sLen);
    pushWord(w);
    applyStimulus(r, l);
    fork
      waitDone(25 + sLen);
      if (sLen > 0) stallAt(sIdx, sLen, w[sIdx]);
    join
  endtask

  task automatic rejectCase(input logic [3:0] r, input logic [11:0] l);
    applyStimulus(r, l);
    @(negedge clk);
    checkOutput("errPulse", 32'(err), 32'd1);
    checkOutput("rejValid", 32'(bit_valid), 32'd0);
    checkOutput("rejBusy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("errOneCycle", 32'(err), 32'd0);
    checkOutput("rejValid2", 32'(bit_valid), 32'd0);
  endtask

  initial begin
    logic [3:0]  r;
    logic [11:0] l;
    int          cnt;
    reset     = 1'b1;
    start     = 1'b0;
    rate      = '0;
    length    = '0;
    bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBitOut", 32'(bit_out), 32'd0);
    checkOutput("rstValid", 32'(bit_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 6 Mbps, length 100, then 54 Mbps, length 1 (hand-derived words)
    runField(4'b1011, 12'd100, 24'h000C8B, 0, 0);
    runField(4'b1100, 12'd1, 24'h02002C, 0, 0);
    runField(4'b1011, 12'd100, 24'h000C8B, 5, 3);
    runField(4'b1100, 12'd1, 24'h02002C, 23, 2);

    rejectCase(4'b0011, 12'd100);
    rejectCase(4'b1011, 12'd0);

    // Reset while bit 10 is on the wire
    pushWord(modelWord(4'b1111, 12'hABC));
    applyStimulus(4'b1111, 12'hABC);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("midRstValid", 32'(bit_valid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || bit_valid || err) cnt++;
    end
    checkOutput("midRstQuiet", 32'(cnt), 32'd0);
    runField(4'b1111, 12'hABC, modelWord(4'b1111, 12'hABC), 0, 0);

    // Start re-pulsed with new inputs while busy must not disturb the field
    pushWord(modelWord(4'b1001, 12'h3C5));
    applyStimulus(4'b1001, 12'h3C5);
    fork
      waitDone(25);
      begin
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        rate   = 4'b1101;
        length = 12'h055;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rate   = 4'b1110;
        length = 12'hFFF;
      end
    join
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bit_valid || busy) cnt++;
    end
    checkOutput("noSecondField", 32'(cnt), 32'd0);

    for (int t = 0; t < 3; t++) begin
      r = {1'b1, 3'($urandom_range(0, 7))};
      l = 12'($urandom_range(1, 4095));
      runField(r, l, modelWord(r, l), 0, 0);
    end

    checkOutput("finalQueue", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
